// File: rtl/stage_seq_pkg.sv
// Shared state encodings and widths for the stage-enable sequencer.
package stage_seq_pkg;

   localparam int unsigned SEQ_STATE_W = 2;

   typedef enum logic [SEQ_STATE_W-1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_FILL  = 2'd1,
      SEQ_RUN   = 2'd2,
      SEQ_DRAIN = 2'd3
   } seq_state_t;

endpackage

// File: rtl/step_divider.sv
// Step dwell counter: emits one tick every STEP_DIV enabled cycles.
module step_divider #(
   parameter int unsigned STEP_DIV = 1
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   logic [CW-1:0] cnt;

   // Tick on the last count of the dwell window.
   assign tick = en && (cnt == CW'(STEP_DIV - 1));

   // Counter: clear wins, otherwise count while enabled and wrap on tick.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/stage_seq.sv
// Thermometer stage-enable sequencer: fill on start, hold full, drain on stop.
module stage_seq
   import stage_seq_pkg::*;
#(
   parameter int unsigned N             = 4,
   parameter int unsigned STEP_DIV      = 1,
   parameter bit          ALLOW_RESTART = 1'b1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   pause,
   output logic [N-1:0]           q,
   output logic [SEQ_STATE_W-1:0] state,
   output logic                   busy,
   output logic                   full,
   output logic                   done
);

   seq_state_t   state_r, state_nx;
   logic [N-1:0] q_nx;
   logic         done_nx;
   logic         cmd;
   logic         shift;
   logic         moving;
   logic         tick;

   assign moving = (state_r == SEQ_FILL) || (state_r == SEQ_DRAIN);
   assign state  = state_r;

   step_divider #(.STEP_DIV(STEP_DIV)) u_div (
      .CLK   (CLK),
      .RST   (RST),
      .clear (cmd || !moving),
      .en    (moving && !pause),
      .tick  (tick)
   );

   // Command decode, shift and completion checks on the post-shift mask.
   always_comb begin
      state_nx = state_r;
      q_nx     = q;
      done_nx  = 1'b0;
      cmd      = 1'b0;
      case (state_r)
         SEQ_IDLE: begin
            if (start && !stop) begin
               state_nx = SEQ_FILL;
               cmd      = 1'b1;
            end
         end
         SEQ_FILL, SEQ_RUN: begin
            if (stop) begin
               state_nx = SEQ_DRAIN;
               cmd      = 1'b1;
            end
         end
         SEQ_DRAIN: begin
            if (ALLOW_RESTART && start && !stop) begin
               state_nx = SEQ_FILL;
               cmd      = 1'b1;
            end
         end
         default: ;
      endcase
      // A command's own shift replaces any divider tick on that edge.
      shift = cmd ? !pause : tick;
      if (shift) begin
         q_nx = {q[N-2:0], (state_nx == SEQ_FILL)};
         if ((state_nx == SEQ_FILL) && (&q_nx)) begin
            state_nx = SEQ_RUN;
         end else if ((state_nx == SEQ_DRAIN) && (q_nx == '0)) begin
            state_nx = SEQ_IDLE;
            done_nx  = 1'b1;
         end
      end
   end

   // State, mask and registered status flags.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= SEQ_IDLE;
         q       <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         full    <= 1'b0;
      end else begin
         state_r <= state_nx;
         q       <= q_nx;
         done    <= done_nx;
         busy    <= (state_nx != SEQ_IDLE);
         full    <= &q_nx;
      end
   end

endmodule

// File: tb/tb_stage_seq.sv
// Bench for stage_seq: three configurations share one stimulus stream.
module tb_stage_seq;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic start = 1'b0, stop = 1'b0, pause = 1'b0;

   logic [3:0] q0, q1;
   logic [7:0] q2;
   logic [1:0] s0, s1, s2;
   logic b0, b1, b2, f0, f1, f2, d0, d1, d2;

   always #5 CLK = ~CLK;

   stage_seq #(.N(4), .STEP_DIV(1), .ALLOW_RESTART(1'b0)) u0 (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop), .pause(pause),
      .q(q0), .state(s0), .busy(b0), .full(f0), .done(d0));
   stage_seq #(.N(4), .STEP_DIV(1), .ALLOW_RESTART(1'b1)) u1 (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop), .pause(pause),
      .q(q1), .state(s1), .busy(b1), .full(f1), .done(d1));
   stage_seq #(.N(8), .STEP_DIV(3), .ALLOW_RESTART(1'b1)) u2 (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop), .pause(pause),
      .q(q2), .state(s2), .busy(b2), .full(f2), .done(d2));

   logic [7:0] aq [3];
   logic [1:0] as_[3];
   logic       ab [3], af [3], ad [3];
   assign aq[0] = 8'(q0);  assign aq[1] = 8'(q1);  assign aq[2] = q2;
   assign as_[0] = s0;     assign as_[1] = s1;     assign as_[2] = s2;
   assign ab[0] = b0;      assign ab[1] = b1;      assign ab[2] = b2;
   assign af[0] = f0;      assign af[1] = f1;      assign af[2] = f2;
   assign ad[0] = d0;      assign ad[1] = d1;      assign ad[2] = d2;

   // Model: phase 0 idle, 1 filling, 2 full, 3 draining; mask kept as a plain byte.
   int         NN [3] = '{4, 4, 8};
   int         DD [3] = '{1, 1, 3};
   bit         RR [3] = '{1'b0, 1'b1, 1'b1};
   int         mph [3] = '{0, 0, 0};
   logic [7:0] mq  [3] = '{8'h0, 8'h0, 8'h0};
   int         left[3] = '{1, 1, 3};
   bit         mdone[3] = '{1'b0, 1'b0, 1'b0};

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s inst%0d t=%0t got %0h want %0h", nm, k, $time, act, exp);
      end
   endtask

   task automatic move(input int k, input logic [7:0] mask);
      mq[k] = ((mq[k] << 1) | 8'(mph[k] == 1)) & mask;
      if (mph[k] == 1 && mq[k] == mask) mph[k] = 2;
      else if (mph[k] == 3 && mq[k] == 8'h0) begin
         mph[k] = 0;
         mdone[k] = 1'b1;
      end
   endtask

   task automatic model_step(input int k, input bit st, input bit sp, input bit pa, input bit rs);
      logic [7:0] mask;
      bit acc;
      int tgt;
      mask = 8'((32'd1 << NN[k]) - 1);
      acc = 1'b0;
      tgt = 0;
      if (rs) begin
         mph[k] = 0; mq[k] = 8'h0; left[k] = DD[k]; mdone[k] = 1'b0;
         return;
      end
      mdone[k] = 1'b0;
      if (mph[k] == 0 && st && !sp) begin acc = 1'b1; tgt = 1; end
      else if ((mph[k] == 1 || mph[k] == 2) && sp) begin acc = 1'b1; tgt = 3; end
      else if (mph[k] == 3 && st && !sp && RR[k]) begin acc = 1'b1; tgt = 1; end
      if (acc) begin
         mph[k] = tgt;
         left[k] = DD[k];
         if (!pa) move(k, mask);
      end else if ((mph[k] == 1 || mph[k] == 3) && !pa) begin
         left[k]--;
         if (left[k] == 0) begin
            left[k] = DD[k];
            move(k, mask);
         end
      end
   endtask

   // One clock: apply inputs, advance model at the edge, compare at the falling edge.
   task automatic cycle(input bit st, input bit sp, input bit pa, input bit rs);
      start = st; stop = sp; pause = pa; RST = rs;
      @(posedge CLK);
      for (int k = 0; k < 3; k++) model_step(k, st, sp, pa, rs);
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
         chk("q", k, 32'(aq[k]), 32'(mq[k]));
         chk("state", k, 32'(as_[k]), 32'(mph[k]));
         chk("busy", k, 32'(ab[k]), 32'(mph[k] != 0));
         chk("full", k, 32'(af[k]), 32'(mq[k] == 8'((32'd1 << NN[k]) - 1)));
         chk("done", k, 32'(ad[k]), 32'(mdone[k]));
      end
   endtask

   int got0, got2;

   initial begin
      // reset state
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      chk("rst_q", 0, 32'(q0), 32'h0);
      chk("rst_state", 0, 32'(s0), 32'h0);

      // basic fill / hold / drain, N=4 D=1
      cycle(1, 0, 0, 0); chk("fill1", 0, 32'(q0), 32'h1);
      cycle(0, 0, 0, 0); chk("fill2", 0, 32'(q0), 32'h3);
      cycle(0, 0, 0, 0); chk("fill3", 0, 32'(q0), 32'h7);
      cycle(0, 0, 0, 0); chk("fill4", 0, 32'(q0), 32'hF);
      chk("run_state", 0, 32'(s0), 32'h2);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
      chk("hold", 0, 32'(q0), 32'hF);
      cycle(0, 1, 0, 0); chk("drain1", 0, 32'(q0), 32'hE);
      cycle(0, 0, 0, 0); chk("drain2", 0, 32'(q0), 32'hC);
      cycle(0, 0, 0, 0); chk("drain3", 0, 32'(q0), 32'h8);
      cycle(0, 0, 0, 0); chk("drain4", 0, 32'(q0), 32'h0);
      chk("done_hi", 0, 32'(d0), 32'h1);
      cycle(0, 0, 0, 0); chk("done_lo", 0, 32'(d0), 32'h0);
      chk("busy_lo", 0, 32'(b0), 32'h0);

      // abort during fill, then restart attempt during drain
      cycle(0, 0, 0, 1);
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0); chk("ab_0011", 0, 32'(q0), 32'h3);
      cycle(0, 1, 0, 0); chk("ab_0110", 0, 32'(q0), 32'h6);
      cycle(0, 0, 0, 0); chk("ab_1100", 1, 32'(q1), 32'hC);
      cycle(1, 0, 0, 0); chk("norestart", 0, 32'(q0), 32'h8);
      chk("restart_1001", 1, 32'(q1), 32'h9);
      cycle(0, 0, 0, 0); chk("ab_done", 0, 32'(d0), 32'h1);
      chk("restart_0011", 1, 32'(q1), 32'h3);
      cycle(0, 0, 0, 0); chk("restart_0111", 1, 32'(q1), 32'h7);
      cycle(0, 0, 0, 0); chk("restart_1111", 1, 32'(q1), 32'hF);
      chk("restart_run", 1, 32'(s1), 32'h2);

      // pause mid-fill with a stop accepted while paused
      cycle(0, 0, 0, 1);
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 1, 1, 0); chk("pause_stop_st", 0, 32'(s0), 32'h3);
      chk("pause_stop_q", 0, 32'(q0), 32'h3);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0); chk("pause_frozen", 0, 32'(q0), 32'h3);
      cycle(0, 0, 0, 0); chk("pause_resume", 0, 32'(q0), 32'h6);
      for (int i = 0; i < 30; i++) cycle(0, 0, 0, 0);

      // reset mid-fill, then start+stop together in idle
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0); chk("pre_rst", 0, 32'(q0), 32'h7);
      cycle(0, 0, 0, 1);
      chk("mid_rst_q", 0, 32'(q0), 32'h0);
      chk("mid_rst_st", 0, 32'(s0), 32'h0);
      chk("mid_rst_done", 0, 32'(d0), 32'h0);
      cycle(1, 1, 0, 0); chk("both_idle", 0, 32'(s0), 32'h0);

      // fill latency with start held: N=8 D=3 full after edge 21
      got0 = -1; got2 = -1;
      cycle(1, 0, 0, 0);
      for (int e = 1; e <= 40; e++) begin
         cycle(1, 0, 0, 0);
         if (got0 < 0 && f0) got0 = e;
         if (got2 < 0 && f2) got2 = e;
      end
      chk("lat_n4d1", 0, 32'(got0), 32'd3);
      chk("lat_n8d3", 2, 32'(got2), 32'd21);
      chk("q_n8_full", 2, 32'(q2), 32'hFF);
      cycle(0, 1, 0, 0);
      for (int i = 0; i < 30; i++) cycle(0, 0, 0, 0);

      // randomized stimulus against the model
      for (int i = 0; i < 4000; i++) begin
         cycle(($urandom % 4) == 0, ($urandom % 14) == 0,
               ($urandom % 6) == 0, ($urandom % 300) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stage_seq.md
# stage_seq

Parametrised pipeline stage-enable sequencer for the count-up pipeline. It ramps an N-bit thermometer valid mask up on `start`, holds it full, then drains it on `stop`. The ramp-up shifts 1s in from the LSB; the drain shifts 0s in from the LSB. It sits between the control front-end and the pipeline stage enables. Over the fixed 4-stage sequencer it adds configurable depth, step dwell, abort-during-fill, restart-during-drain, pause, and status/done outputs.

## Interface
- `N`, 4: stage count, width of `q`; legal range N ≥ 2.
- `STEP_DIV`, 1: clock cycles per shift step; legal range ≥ 1.
- `ALLOW_RESTART`, 1: 1 means `start` is accepted in DRAIN; 0 means it is ignored there.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin fill; level-sampled every edge.
- `stop`  in  1  begin drain; level-sampled; has priority over `start`.
- `pause`  in  1  freeze `q` and divider while in FILL/DRAIN.
- `q`  out  N  stage-valid mask; bit 0 = first stage.
- `state`  out  2  IDLE=0, FILL=1, RUN=2, DRAIN=3.
- `busy`  out  1  state != IDLE.
- `full`  out  1  q == all ones.
- `done`  out  1  one-cycle pulse on drain completion.

## Operation
- Reset (RST high at edge): q=0, state=IDLE, divider=0, done=0.
- Shift operation: q <= {q[N-2:0], feed}.
  - feed=1 when the resulting state is FILL.
  - feed=0 when the resulting state is DRAIN.
- Accepted commands:
  - start in IDLE, with stop low.
  - stop in FILL or RUN.
  - start in DRAIN, with stop low and ALLOW_RESTART=1.
  - All other command/state combinations are ignored.
- On an accepted command edge:
  - state updates.
  - One shift is performed immediately, unless pause is high.
  - Divider clears to 0.
- Divider behaviour:
  - Counts 0..STEP_DIV-1 only in FILL/DRAIN with pause low.
  - Produces a step tick when it equals STEP_DIV-1, then wraps to 0.
  - Each tick performs one shift.
  - Held at 0 in IDLE and RUN.
- FILL: shift 1s on each tick. The edge at which q becomes all ones moves to RUN.
- RUN: q holds all ones until stop.
- DRAIN: shift 0s on each tick. The edge at which q becomes 0 moves to IDLE and registers done=1 for one cycle.
- stop in FILL (abort): the partial wave keeps travelling upward with 0s behind it. Example N=4: 0011 → 0110 → 1100 → 1000 → 0000.
- Restart in DRAIN: shift 1s again from the current q. Example: 1100 → 1001 → 0011 → 0111 → 1111.
  - FILL→RUN still requires q all ones.
- pause:
  - Freezes q and the divider only.
  - Commands are still accepted and change state, but their immediate shift is suppressed.
  - Shifting resumes on ticks after pause falls.
- Simultaneous start and stop:
  - In IDLE or DRAIN: nothing happens, because stop has priority and stop is ignored in those states.
  - In FILL or RUN: treated as stop.
- RST mid-operation: returns to the reset state at that edge; no done pulse.

## Timing
- All outputs are registered; `busy`, `full`, and `state` reflect current registers.
- Latency with STEP_DIV=D:
  - Start accepted at edge 0 gives q=0…01 after edge 0.
  - Each further bit follows every D edges.
  - Full after edge (N-1)·D.
- Drain of a full mask: q=0 after edge (N-1)·D counted from the stop edge. done is high for the following cycle only.
- N=4, D=1 timing: 0001, 0011, 0111, 1111 on successive edges; stop gives 1110, 1100, 1000, 0000.

## Structure
- Shared package `stage_seq_pkg` holds:
  - state encodings `SEQ_IDLE`, `SEQ_FILL`, `SEQ_RUN`, `SEQ_DRAIN`;
  - the 2-bit state width constant.
- One sub-module, `step_divider`:
  - parameter STEP_DIV;
  - inputs `clear` and `en`;
  - output `tick`;
  - counter width $clog2(STEP_DIV), minimum 1.
- The top level holds the FSM, the shift register, and the done register.

## Test plan
- N=4, D=1: start pulse, then stop 3 cycles after full → q=0001, 0011, 0111, 1111 (hold, state=2), then 1110, 1100, 1000, 0000; done high exactly one cycle; busy low afterwards.
- N=8, D=3: start held → a new bit every 3 cycles; full asserts 21 cycles after the start edge.
- N=4, D=1, abort: stop at q=0011 → 0110, 1100, 1000, 0000; done pulses; start during the drain with ALLOW_RESTART=0 → ignored.
- ALLOW_RESTART=1: start at q=1100 in DRAIN → 1001, 0011, 0111, 1111; state=RUN.
- pause held 5 cycles mid-FILL → q frozen, divider frozen; stop accepted during pause changes state to DRAIN with no shift; the first 0 shifts in on the edge after pause falls (D=1).
- RST asserted at q=0111 → q=0, state=0, done=0 on the next edge; start+stop together in IDLE → stays IDLE.
